wrr_arb_ctrl: RTL

Weighted round-robin scheduler that shares the single downstream output port D between three first-word-fall-through channel FIFOs (A, B, C). It grants each non-empty channel a burst of up to its programmed weight, pops that FIFO directly, and drives a registered valid/grant output stage toward D. It replaces plain one-word round-robin where per-channel bandwidth shares are needed.

---
 rtl/wrr_arb_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/wrr_arb_ctrl.sv
// Weighted round-robin scheduler: three FWFT channel FIFOs share output port D,
// each non-empty channel getting a burst of up to its programmed weight.
module wrr_arb_ctrl #(
    parameter int WIDTH = 8,
    parameter int WGT_W = 3
) (
    input  logic             CLK,
    input  logic             ASynReset_N,
    input  logic             i_Empty_A,
    input  logic             i_Empty_B,
    input  logic             i_Empty_C,
    input  logic [WIDTH-1:0] i_Data_A,
    input  logic [WIDTH-1:0] i_Data_B,
    input  logic [WIDTH-1:0] i_Data_C,
    input  logic [WGT_W-1:0] i_Weight_A,
    input  logic [WGT_W-1:0] i_Weight_B,
    input  logic [WGT_W-1:0] i_Weight_C,
    input  logic             i_CfgLoad,
    input  logic             i_DataGrant_D,
    output logic             o_Pop_A,
    output logic             o_Pop_B,
    output logic             o_Pop_C,
    output logic             o_DataValid_D,
    output logic [WIDTH-1:0] o_DataOut_D,
    output logic [1:0]       o_Owner,
    output logic             o_CfgPending
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state_reg;
    logic [WGT_W-1:0] cnt_reg;
    logic [1:0]       own_idx_reg;
    logic [1:0]       last_idx_reg;
    logic [1:0]       owner_reg;
    logic [WGT_W-1:0] wgt_act_reg  [3];
    logic [WGT_W-1:0] wgt_pend_reg [3];
    logic             pend_reg;
    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;

    logic [2:0]       empty_vec;
    logic [WIDTH-1:0] data_vec [3];
    logic [WGT_W-1:0] wgt_in   [3];
    logic [WGT_W-1:0] wgt_eff  [3];
    logic [2:0]       elig;
    logic [2:0]       pop_vec;

    logic             sel_valid;
    logic [1:0]       sel_idx;
    logic [2:0]       sel_sum;
    logic [1:0]       sel_cand;

    logic             can_load;
    logic             owner_empty;
    logic [WIDTH-1:0] owner_data;
    logic             do_pop;

    assign empty_vec   = {i_Empty_C, i_Empty_B, i_Empty_A};
    assign data_vec[0] = i_Data_A;
    assign data_vec[1] = i_Data_B;
    assign data_vec[2] = i_Data_C;
    assign wgt_in[0]   = i_Weight_A;
    assign wgt_in[1]   = i_Weight_B;
    assign wgt_in[2]   = i_Weight_C;

    // Pending weights take effect in the same IDLE cycle that applies them.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_elig
            assign wgt_eff[gi] = pend_reg ? wgt_pend_reg[gi] : wgt_act_reg[gi];
            assign elig[gi]    = !empty_vec[gi] && (wgt_eff[gi] != '0);
        end
    endgenerate

    // Scan offsets from farthest to nearest so the nearest eligible channel wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = 2'd0;
        sel_sum   = 3'd0;
        sel_cand  = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            sel_sum = {1'b0, last_idx_reg} + 3'(k);
            if (sel_sum >= 3'd3) begin
                sel_sum = sel_sum - 3'd3;
            end
            sel_cand = sel_sum[1:0];
            if (elig[sel_cand]) begin
                sel_valid = 1'b1;
                sel_idx   = sel_cand;
            end
        end
    end

    assign can_load    = !valid_reg || i_DataGrant_D;
    assign owner_empty = empty_vec[own_idx_reg];
    assign owner_data  = data_vec[own_idx_reg];
    assign do_pop      = (state_reg == BURST) && can_load && !owner_empty;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_pop
            assign pop_vec[gi] = do_pop && (own_idx_reg == 2'(gi));
        end
    endgenerate

    always_ff @(posedge CLK or negedge ASynReset_N) begin
        if (!ASynReset_N) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            own_idx_reg  <= 2'd0;
            last_idx_reg <= 2'd2;
            owner_reg    <= 2'd0;
            pend_reg     <= 1'b0;
            valid_reg    <= 1'b0;
            data_reg     <= '0;
            for (int i = 0; i < 3; i++) begin
                wgt_act_reg[i]  <= WGT_W'(1);
                wgt_pend_reg[i] <= WGT_W'(1);
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pend_reg) begin
                        for (int i = 0; i < 3; i++) begin
                            wgt_act_reg[i] <= wgt_pend_reg[i];
                        end
                    end
                    if (sel_valid) begin
                        state_reg    <= BURST;
                        cnt_reg      <= wgt_eff[sel_idx];
                        own_idx_reg  <= sel_idx;
                        last_idx_reg <= sel_idx;
                        owner_reg    <= sel_idx + 2'd1;
                    end
                end
                BURST: begin
                    if (owner_empty) begin
                        state_reg <= IDLE;
                        owner_reg <= 2'd0;
                    end else if (can_load) begin
                        cnt_reg <= cnt_reg - WGT_W'(1);
                        if (cnt_reg == WGT_W'(1)) begin
                            state_reg <= IDLE;
                            owner_reg <= 2'd0;
                        end
                    end
                end
            endcase

            // A strobe always lands in the pending set, even in the cycle IDLE consumes it.
            if (i_CfgLoad) begin
                pend_reg <= 1'b1;
                for (int i = 0; i < 3; i++) begin
                    wgt_pend_reg[i] <= wgt_in[i];
                end
            end else if (state_reg == IDLE) begin
                pend_reg <= 1'b0;
            end

            if (do_pop) begin
                data_reg  <= owner_data;
                valid_reg <= 1'b1;
            end else if (i_DataGrant_D) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign o_Pop_A       = pop_vec[0];
    assign o_Pop_B       = pop_vec[1];
    assign o_Pop_C       = pop_vec[2];
    assign o_DataValid_D = valid_reg;
    assign o_DataOut_D   = data_reg;
    assign o_Owner       = owner_reg;
    assign o_CfgPending  = pend_reg;

endmodule
